// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: opcode bus, ME_* opcodes,
// register bus types and MEM state encodings.
package mem_access_pkg;

  typedef logic [7:0]  AluOpBus;
  typedef logic [31:0] RegBus;
  typedef logic [4:0]  RegAddrBus;

  localparam logic  RstEnable = 1'b1;
  localparam RegBus ZeroWord  = 32'h0000_0000;

  localparam AluOpBus ME_NOP_OP = 8'h00;
  localparam AluOpBus ME_LB_OP  = 8'h20;
  localparam AluOpBus ME_LH_OP  = 8'h21;
  localparam AluOpBus ME_LW_OP  = 8'h23;
  localparam AluOpBus ME_LBU_OP = 8'h24;
  localparam AluOpBus ME_LHU_OP = 8'h25;
  localparam AluOpBus ME_SB_OP  = 8'h28;
  localparam AluOpBus ME_SH_OP  = 8'h29;
  localparam AluOpBus ME_SW_OP  = 8'h2B;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } mem_state_e;

  // Bytes moved by an opcode; 0 marks anything that is not a memory op.
  function automatic logic [2:0] me_nbytes(input AluOpBus op);
    case (op)
      ME_LB_OP, ME_LBU_OP, ME_SB_OP: me_nbytes = 3'd1;
      ME_LH_OP, ME_LHU_OP, ME_SH_OP: me_nbytes = 3'd2;
      ME_LW_OP, ME_SW_OP:            me_nbytes = 3'd4;
      default:                       me_nbytes = 3'd0;
    endcase
  endfunction

  function automatic logic me_is_store(input AluOpBus op);
    me_is_store = (op == ME_SB_OP) || (op == ME_SH_OP) || (op == ME_SW_OP);
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load result shaping: picks the loaded width out of the byte buffer and
// sign- or zero-extends it to a full register.
module mem_load_ext
  import mem_access_pkg::*;
(
  input  RegBus   buf_i,
  input  AluOpBus aluop_i,
  output RegBus   data_o
);

  // Width/extension select; LW and non-loads see the buffer as-is.
  always_comb begin
    data_o = buf_i;
    case (aluop_i)
      ME_LB_OP:  data_o = {{24{buf_i[7]}}, buf_i[7:0]};
      ME_LBU_OP: data_o = {24'h000000, buf_i[7:0]};
      ME_LH_OP:  data_o = {{16{buf_i[15]}}, buf_i[15:0]};
      ME_LHU_OP: data_o = {16'h0000, buf_i[15:0]};
      default:   data_o = buf_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: serialises loads/stores into byte requests on the arbiter
// port (little-endian), stalls the pipeline until done, then hands the
// writeback data to MEM/WB for exactly one cycle.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  RegAddrBus             wd_i,
  input  logic                  wreg_i,
  input  RegBus                 wdata_i,
  input  AluOpBus               aluop_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic                  mem_grant_i,
  input  logic [7:0]            mem_din_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [7:0]            mem_dout_o,
  output RegAddrBus             wd_o,
  output logic                  wreg_o,
  output RegBus                 wdata_o,
  output logic                  stall_req_o
);

  mem_state_e state_q, state_d;
  logic [2:0] issue_q, issue_d;
  logic [2:0] recv_q, recv_d;
  RegBus      buf_q, buf_d;
  logic       rd_pend_q, rd_pend_d;  // a read was granted last cycle

  logic [2:0] nbytes;
  logic       is_store, is_load, req;
  RegBus      ext_data;

  assign nbytes   = me_nbytes(aluop_i);
  assign is_store = me_is_store(aluop_i);
  assign is_load  = (nbytes != 3'd0) && !is_store;
  assign req      = (state_q == MEM_ACCESS) && (issue_q < nbytes);

  mem_load_ext u_ext (
    .buf_i   (buf_q),
    .aluop_i (aluop_i),
    .data_o  (ext_data)
  );

  // State, counters and byte buffer; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= MEM_IDLE;
      issue_q   <= 3'd0;
      recv_q    <= 3'd0;
      buf_q     <= ZeroWord;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      issue_q   <= issue_d;
      recv_q    <= recv_d;
      buf_q     <= buf_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Next state: issue on grant, capture read bytes one cycle later.
  always_comb begin
    state_d   = state_q;
    issue_d   = issue_q;
    recv_d    = recv_q;
    buf_d     = buf_q;
    rd_pend_d = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (nbytes != 3'd0) begin
          state_d = MEM_ACCESS;
          issue_d = 3'd0;
          recv_d  = 3'd0;
          buf_d   = ZeroWord;
        end
      end
      MEM_ACCESS: begin
        if (nbytes == 3'd0) begin
          // opcode vanished under a held latch; nothing sensible to finish
          state_d = MEM_IDLE;
        end else begin
          if (req && mem_grant_i) begin
            issue_d   = issue_q + 3'd1;
            rd_pend_d = !is_store;
            if (is_store && (issue_q == nbytes - 3'd1)) state_d = MEM_DONE;
          end
          if (rd_pend_q) begin
            buf_d[{recv_q[1:0], 3'b000} +: 8] = mem_din_i;
            recv_d = recv_q + 3'd1;
            if (recv_q == nbytes - 3'd1) state_d = MEM_DONE;
          end
        end
      end
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  // Outputs: byte port while issuing, pass-through in IDLE, result in DONE.
  always_comb begin
    mem_req_o   = req;
    mem_we_o    = req && is_store;
    mem_addr_o  = req ? (mem_addr_i + ADDR_WIDTH'(issue_q)) : '0;
    mem_dout_o  = (req && is_store) ? wdata_i[{issue_q[1:0], 3'b000} +: 8] : 8'h00;
    wd_o        = wd_i;
    wreg_o      = 1'b0;
    wdata_o     = ZeroWord;
    stall_req_o = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (nbytes == 3'd0) begin
          wreg_o  = wreg_i;
          wdata_o = wdata_i;
        end else begin
          stall_req_o = 1'b1;
        end
      end
      MEM_ACCESS: stall_req_o = 1'b1;
      MEM_DONE: begin
        if (is_load) begin
          wreg_o  = wreg_i;
          wdata_o = ext_data;
        end
      end
      default: ;
    endcase
    if (rst == RstEnable) begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_dout_o  = 8'h00;
      wd_o        = '0;
      wreg_o      = 1'b0;
      wdata_o     = ZeroWord;
      stall_req_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: byte-memory model on the arbiter
// port, writeback scoreboard, and one task per scenario.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  RegAddrBus   wd_i;
  logic        wreg_i;
  RegBus       wdata_i;
  AluOpBus     aluop_i;
  logic [31:0] mem_addr_i;
  logic        mem_grant_i;
  logic [7:0]  mem_din_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_dout_o;
  RegAddrBus   wd_o;
  logic        wreg_o;
  RegBus       wdata_o;
  logic        stall_req_o;

  typedef struct packed { logic [4:0] wd; logic wreg; logic [31:0] wdata; } wb_t;
  typedef struct packed { logic [31:0] addr; logic we; logic [7:0] dout; } req_t;

  wb_t  exp_q[$];
  req_t obs_q[$];
  logic [7:0] mem [bit [31:0]];
  int n_tests = 0;
  int n_fail  = 0;
  req_t       mreq;
  bit  [31:0] maddr;

  always #5 clk = ~clk;

  mem_access #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .mem_grant_i(mem_grant_i),
    .mem_din_i(mem_din_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_dout_o(mem_dout_o), .wd_o(wd_o),
    .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_req_o(stall_req_o)
  );

  // Byte memory: logs granted requests, returns read data next cycle,
  // garbage on every other cycle.
  always @(posedge clk) begin
    mem_din_i <= 8'($urandom);
    if (!rst && mem_req_o && mem_grant_i) begin
      mreq.addr = mem_addr_o;
      mreq.we   = mem_we_o;
      mreq.dout = mem_dout_o;
      obs_q.push_back(mreq);
      maddr = mem_addr_o;
      if (!mem_we_o) mem_din_i <= mem.exists(maddr) ? mem[maddr] : 8'h00;
    end
  end

  task automatic drive(input AluOpBus op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] wd, input logic wreg);
    aluop_i = op; mem_addr_i = addr; wdata_i = wdata; wd_i = wd; wreg_i = wreg;
  endtask

  // Issue one instruction, wait for its writeback cycle, check result,
  // stall length and the byte requests it made.
  task automatic run_op(input string name, input AluOpBus op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] exp_wdata, input logic exp_wreg,
                        input int exp_stall, input int exp_nreq, input logic exp_we);
    wb_t  e, got;
    req_t r;
    int   stalls;
    e.wd = wd; e.wreg = exp_wreg; e.wdata = exp_wdata;
    exp_q.push_back(e);
    @(posedge clk); #1;
    obs_q.delete();
    drive(op, addr, wdata, wd, wreg);
    stalls = 0;
    @(negedge clk);
    while (stall_req_o && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    n_tests++;
    if (stall_req_o) begin
      n_fail++;
      $display("FAIL %s timeout: stall_req_o still 1 after %0d cycles", name, stalls);
      return;
    end
    got.wd = wd_o; got.wreg = wreg_o; got.wdata = wdata_o;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s wb: got wd=%0d wreg=%b wdata=%h, want wd=%0d wreg=%b wdata=%h",
               name, got.wd, got.wreg, got.wdata, e.wd, e.wreg, e.wdata);
    end
    n_tests++;
    if (stalls != exp_stall) begin
      n_fail++;
      $display("FAIL %s stall: got %0d cycles, want %0d", name, stalls, exp_stall);
    end
    n_tests++;
    if (mem_req_o !== 1'b0 || obs_q.size() != exp_nreq) begin
      n_fail++;
      $display("FAIL %s reqs: got %0d granted (req now %b), want %0d (req 0)",
               name, obs_q.size(), mem_req_o, exp_nreq);
    end else begin
      for (int i = 0; i < exp_nreq; i++) begin
        r = obs_q[i];
        n_tests++;
        if (r.addr !== addr + 32'(i) || r.we !== exp_we ||
            (exp_we && r.dout !== wdata[8*i +: 8])) begin
          n_fail++;
          $display("FAIL %s req%0d: got addr=%h we=%b dout=%h, want addr=%h we=%b dout=%h",
                   name, i, r.addr, r.we, r.dout, addr + 32'(i), exp_we,
                   exp_we ? wdata[8*i +: 8] : r.dout);
        end
      end
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    drive(ME_NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic test_reset();
    drive(ME_LW_OP, 32'h100, 32'hFFFF_FFFF, 5'd7, 1'b1);
    repeat (3) @(negedge clk);
    n_tests++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_dout_o, wd_o, wreg_o, wdata_o, stall_req_o} !== 81'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h dout=%h wd=%0d wreg=%b wdata=%h stall=%b, want all 0",
               mem_req_o, mem_we_o, mem_addr_o, mem_dout_o, wd_o, wreg_o, wdata_o, stall_req_o);
    end
    drive(ME_NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_lw();
    mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
    run_op("lw", ME_LW_OP, 32'h100, 32'h0, 5'd5, 1'b1, 32'h1234_5678, 1'b1, 6, 4, 1'b0);
    go_idle();
  endtask

  task automatic test_sign_ext();
    mem[32'h10] = 8'h80; mem[32'h21] = 8'h01; mem[32'h22] = 8'h80;
    run_op("lb",  ME_LB_OP,  32'h10, 32'h0, 5'd1, 1'b1, 32'hFFFF_FF80, 1'b1, 3, 1, 1'b0);
    run_op("lbu", ME_LBU_OP, 32'h10, 32'h0, 5'd2, 1'b1, 32'h0000_0080, 1'b1, 3, 1, 1'b0);
    run_op("lh",  ME_LH_OP,  32'h21, 32'h0, 5'd3, 1'b1, 32'hFFFF_8001, 1'b1, 4, 2, 1'b0);
    run_op("lhu", ME_LHU_OP, 32'h21, 32'h0, 5'd4, 1'b1, 32'h0000_8001, 1'b1, 4, 2, 1'b0);
    go_idle();
  endtask

  task automatic test_store();
    run_op("sh", ME_SH_OP, 32'h203, 32'hABCD_1234, 5'd9, 1'b1, 32'h0, 1'b0, 3, 2, 1'b1);
    run_op("sb", ME_SB_OP, 32'h400, 32'h0000_00A5, 5'd8, 1'b1, 32'h0, 1'b0, 2, 1, 1'b1);
    run_op("sw_wrap", ME_SW_OP, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 5'd6, 1'b1, 32'h0, 1'b0, 5, 4, 1'b1);
    go_idle();
    // the bytes written at the wrap must not reach the bench memory model
    // through the read path; just verify no request follows DONE
    @(negedge clk);
    n_tests++;
    if (mem_req_o !== 1'b0 || stall_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL store_idle: req=%b stall=%b, want 0 0", mem_req_o, stall_req_o);
    end
  endtask

  // LW with grant withheld for three cycles once two bytes are in.
  task automatic test_grant_gap();
    int stalls, granted, gap;
    wb_t e;
    mem[32'h100] = 8'hEF; mem[32'h101] = 8'hBE; mem[32'h102] = 8'hAD; mem[32'h103] = 8'hDE;
    e.wd = 5'd11; e.wreg = 1'b1; e.wdata = 32'hDEAD_BEEF;
    exp_q.push_back(e);
    @(posedge clk); #1;
    obs_q.delete();
    drive(ME_LW_OP, 32'h100, 32'h0, 5'd11, 1'b1);
    stalls = 0; granted = 0; gap = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!stall_req_o) break;
      stalls++;
      if (granted == 2 && gap < 3) begin
        mem_grant_i = 1'b0;
        gap++;
        n_tests++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h102) begin
          n_fail++;
          $display("FAIL gap_hold%0d: req=%b addr=%h, want req=1 addr=00000102", gap, mem_req_o, mem_addr_o);
        end
      end else begin
        mem_grant_i = 1'b1;
      end
      if (mem_req_o && mem_grant_i) granted++;
    end
    mem_grant_i = 1'b1;
    e = exp_q.pop_front();
    n_tests++;
    if (stall_req_o || wreg_o !== e.wreg || wdata_o !== e.wdata || wd_o !== e.wd) begin
      n_fail++;
      $display("FAIL gap_wb: stall=%b wd=%0d wreg=%b wdata=%h, want stall=0 wd=%0d wreg=%b wdata=%h",
               stall_req_o, wd_o, wreg_o, wdata_o, e.wd, e.wreg, e.wdata);
    end
    n_tests++;
    if (stalls != 9 || obs_q.size() != 4) begin
      n_fail++;
      $display("FAIL gap_stall: got %0d stalls %0d reqs, want 9 stalls 4 reqs", stalls, obs_q.size());
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    mem[32'h500] = 8'h11; mem[32'h501] = 8'h22; mem[32'h502] = 8'h33; mem[32'h503] = 8'h44;
    mem[32'h600] = 8'hC0; mem[32'h601] = 8'hFF; mem[32'h602] = 8'hEE; mem[32'h603] = 8'h0D;
    run_op("add", ME_NOP_OP, 32'h0, 32'h0000_0055, 5'd10, 1'b1, 32'h0000_0055, 1'b1, 0, 0, 1'b0);
    run_op("lw_a", ME_LW_OP, 32'h500, 32'h0, 5'd12, 1'b1, 32'h4433_2211, 1'b1, 6, 4, 1'b0);
    run_op("lw_b", ME_LW_OP, 32'h600, 32'h0, 5'd13, 1'b1, 32'h0DEE_FFC0, 1'b1, 6, 4, 1'b0);
    run_op("unk_op", 8'h7F, 32'h0, 32'hCAFE_F00D, 5'd14, 1'b1, 32'hCAFE_F00D, 1'b1, 0, 0, 1'b0);
    go_idle();
  endtask

  // Reset in the middle of an SW: access dropped, block back in IDLE.
  task automatic test_reset_mid();
    @(posedge clk); #1;
    drive(ME_SW_OP, 32'h700, 32'h1122_3344, 5'd15, 1'b1);
    repeat (3) @(negedge clk);
    n_tests++;
    if (mem_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: req=%b, want 1", mem_req_o);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    drive(ME_NOP_OP, 32'h0, 32'h0000_0077, 5'd3, 1'b1);
    @(negedge clk);
    n_tests++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_dout_o, wd_o, wreg_o, wdata_o, stall_req_o} !== 81'b0) begin
      n_fail++;
      $display("FAIL rstmid_zero: req=%b we=%b addr=%h wreg=%b wdata=%h stall=%b, want all 0",
               mem_req_o, mem_we_o, mem_addr_o, wreg_o, wdata_o, stall_req_o);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (stall_req_o !== 1'b0 || mem_req_o !== 1'b0 || wreg_o !== 1'b1 || wdata_o !== 32'h77 || wd_o !== 5'd3) begin
      n_fail++;
      $display("FAIL rstmid_idle: stall=%b req=%b wd=%0d wreg=%b wdata=%h, want 0 0 3 1 00000077",
               stall_req_o, mem_req_o, wd_o, wreg_o, wdata_o);
    end
    go_idle();
  endtask

  initial begin
    rst = 1'b1;
    mem_grant_i = 1'b1;
    drive(ME_NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0);
    test_reset();
    test_lw();
    test_sign_ext();
    test_store();
    test_grant_gap();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the five-stage RV32I pipeline. Consumes the EX/MEM latch outputs: destination register, write enable, ALU result or store data, memory opcode and effective address.
- Performs loads and stores over the byte-wide memory-arbiter port, one byte per granted request, little-endian.
- Holds the pipeline via stall_req_o until the access completes, then presents writeback data to MEM/WB.
- Non-memory instructions pass through combinationally.

Parameters:
- ADDR_WIDTH, 32, width of the effective address and of mem_addr_o.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset; synchronous, active-high.
- wd_i  in  5  destination register from EX/MEM.
- wreg_i  in  1  register write enable from EX/MEM.
- wdata_i  in  32  ALU result, or store data for store ops.
- aluop_i  in  AluOpBus  ME_* opcode; ME_NOP_OP means no memory access.
- mem_addr_i  in  ADDR_WIDTH  effective address.
- mem_grant_i  in  1  arbiter accepts the current byte request this cycle.
- mem_din_i  in  8  read byte, valid the cycle after a granted read.
- mem_req_o  out  1  byte request.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  ADDR_WIDTH  byte address.
- mem_dout_o  out  8  write byte.
- wd_o  out  5  to MEM/WB.
- wreg_o  out  1  to MEM/WB.
- wdata_o  out  32  to MEM/WB.
- stall_req_o  out  1  to pipeline control; stalls all earlier stages.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; issue count, receive count and byte buffer cleared. While rst=1 all outputs are 0. Reset mid-access abandons the access; mem_req_o is 0 from the next cycle.
- Byte count N: LB/LBU/SB = 1; LH/LHU/SH = 2; LW/SW = 4.
- States:
  - IDLE: if aluop_i is ME_NOP_OP, pass through: wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i, stall_req_o=0, zero latency. Otherwise stall_req_o=1, wreg_o=0, wdata_o=0, and go to ACCESS with counts cleared.
  - ACCESS: stall_req_o=1, wreg_o=0.
    - While issue count < N: mem_req_o=1, mem_addr_o = mem_addr_i + issue (mod 2^ADDR_WIDTH), mem_we_o = store op.
    - mem_dout_o = wdata_i byte[issue], i.e. bits [8*issue+7 : 8*issue].
    - Issue count increments only on a cycle with mem_grant_i=1. Without grant, address, data and we are held unchanged.
    - Loads: on the cycle after each granted read, mem_din_i is captured into buffer byte[receive] and receive increments.
    - Exit to DONE: stores when the last byte is granted; loads when the last byte is captured.
  - DONE: exactly one cycle, stall_req_o=0, mem_req_o=0, wd_o=wd_i.
    - Loads: wreg_o=wreg_i; wdata_o = extended buffer. LB/LH sign-extend; LBU/LHU zero-extend; LW uses the buffer unchanged.
    - Stores: wreg_o=0, wdata_o=0.
    - The EX/MEM latch advances at the end of this cycle. Next state IDLE, so a following memory op starts on the next cycle.
- Latency with grant held high: LW stalls 6 cycles, then DONE; SW stalls 5 cycles, then DONE.
- Misaligned addresses need no special handling; each byte is addressed individually. Address wrap at 0xFFFFFFFF goes to 0.
- Unknown aluop_i values are treated as ME_NOP_OP.
- mem_grant_i while mem_req_o=0 is ignored. mem_din_i is ignored except on capture cycles.

Decomposition:
- Shared defines header holds:
  - ME_* opcodes: ME_NOP_OP, LB, LH, LW, LBU, LHU, SB, SH, SW.
  - AluOpBus, RegBus, RegAddrBus, RstEnable, ZeroWord.
  - MEM state encodings IDLE / ACCESS / DONE.
- One sub-module, mem_load_ext: combinational load width and sign extension (buffer + opcode -> 32-bit value).

Test Plan:
- LW at 0x100, memory bytes 78 56 34 12, grant always 1 -> requests at 0x100..0x103; stall_req_o high 6 cycles; DONE wdata_o=0x12345678, wreg_o=1.
- LB of byte 0x80 -> wdata_o=0xFFFFFF80; LBU of the same byte -> 0x00000080; LH of 0x8001 -> 0xFFFF8001.
- SH, wdata_i=0xABCD1234, address 0x203 -> writes 0x34@0x203 then 0x12@0x204, mem_we_o=1; DONE has wreg_o=0; no third request.
- LW with grant dropped for 3 cycles after the second byte -> mem_addr_o held at 0x101+1 through the gap; result still correct; stall lengthened by 3.
- rst asserted during ACCESS of an SW -> next cycle mem_req_o=0, state IDLE, all outputs 0.
- ADD result 0x55 with wreg=1, then back-to-back LW, LW -> ADD passes through with stall 0; second load begins the cycle after the first's DONE.
